// File: rtl/sysid_caps.sv
// sysid_caps: CSR-mapped system identification and capability block.
// Provides a SoC ID, build-time capability words with a lockable runtime
// enable mask, a 64-bit cycle counter with a coherent high-half snapshot,
// and a scratch register.

module sysid_caps #(
  parameter logic [3:0]              CSR_ADDR  = 4'h0,
  parameter int                      CAP_WORDS = 2,
  parameter logic [32*CAP_WORDS-1:0] CAP_BUILD = {CAP_WORDS{32'h0000_0040}},
  parameter logic [31:0]             SOC_ID    = 32'h4D4D534F
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [13:0]               csr_a,
  input  logic                      csr_we,
  input  logic [31:0]               csr_di,
  output logic [31:0]               csr_do,
  output logic [32*CAP_WORDS-1:0]   cap_en
);

  localparam logic [4:0] IDX_ID      = 5'h00;
  localparam logic [4:0] IDX_CTRL    = 5'h01;
  localparam logic [4:0] IDX_CNT_LO  = 5'h02;
  localparam logic [4:0] IDX_CNT_HI  = 5'h03;
  localparam logic [4:0] IDX_SCRATCH = 5'h04;

  logic                      sel;
  logic [4:0]                idx;
  logic                      wr;
  logic                      clr_pulse;
  logic                      snap_load;
  logic [31:0]               rdata;

  logic                      lock;
  logic                      run;
  logic [63:0]               counter;
  logic [31:0]               snap;
  logic [31:0]               scratch;
  logic [32*CAP_WORDS-1:0]   mask;

  // Address bits [9:5] are don't-care inside the bank.
  logic                      unused_addr_bits;
  assign unused_addr_bits = ^csr_a[9:5];

  assign sel       = (csr_a[13:10] == CSR_ADDR);
  assign idx       = csr_a[4:0];
  assign wr        = sel & csr_we;
  assign clr_pulse = wr & (idx == IDX_CTRL) & csr_di[1];
  assign snap_load = sel & ~csr_we & (idx == IDX_CNT_LO);

  // Mask only ever holds built bits, so the AND is a safety net that keeps
  // cap_en a pure function of registered state.
  assign cap_en = CAP_BUILD & mask;

  // Read multiplexer: the addressed register value, zero for holes.
  always_comb begin
    rdata = '0;
    case (idx)
      IDX_ID:      rdata = SOC_ID;
      IDX_CTRL:    rdata = {29'd0, run, 1'b0, lock};
      IDX_CNT_LO:  rdata = counter[31:0];
      IDX_CNT_HI:  rdata = snap;
      IDX_SCRATCH: rdata = scratch;
      default: begin
        for (int k = 0; k < CAP_WORDS; k++) begin
          if (idx == 5'(8 + k))  rdata = CAP_BUILD[32*k +: 32];
          if (idx == 5'(16 + k)) rdata = mask[32*k +: 32];
        end
      end
    endcase
  end

  // Registered read data; a write in the same cycle still returns the old value.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) csr_do <= '0;
    else         csr_do <= sel ? rdata : 32'd0;
  end

  // Control bits: lock is sticky until reset, run is a plain RW bit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lock <= 1'b0;
      run  <= 1'b1;
    end else if (wr && idx == IDX_CTRL) begin
      lock <= lock | csr_di[0];
      run  <= csr_di[2];
    end
  end

  // Free-running cycle counter; a clear write wins over the increment.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)        counter <= '0;
    else if (clr_pulse) counter <= '0;
    else if (run)       counter <= counter + 64'd1;
  end

  // Capture the high half whenever the low half is read, for a coherent pair.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)        snap <= '0;
    else if (snap_load) snap <= counter[63:32];
  end

  // Scratch register for software use.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                        scratch <= '0;
    else if (wr && idx == IDX_SCRATCH)  scratch <= csr_di;
  end

  // Capability mask: writable only while unlocked, never beyond built bits.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mask <= CAP_BUILD;
    end else if (wr && !lock) begin
      for (int k = 0; k < CAP_WORDS; k++) begin
        if (idx == 5'(16 + k))
          mask[32*k +: 32] <= csr_di & CAP_BUILD[32*k +: 32];
      end
    end
  end

endmodule

// File: tb/tb_sysid_caps.sv
// tb_sysid_caps: directed self-checking bench for sysid_caps.

module tb_sysid_caps;

  localparam int              CAP_WORDS = 2;
  localparam logic [63:0]     BUILD     = 64'h0000_0040_0000_0041;
  localparam logic [31:0]     ID_VAL    = 32'h4D4D534F;
  localparam logic [3:0]      BANK      = 4'h3;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [13:0]   csr_a;
  logic          csr_we;
  logic [31:0]   csr_di;
  logic [31:0]   csr_do;
  logic [63:0]   cap_en;

  int tests_run = 0;
  int tests_failed = 0;

  sysid_caps #(
    .CSR_ADDR  (BANK),
    .CAP_WORDS (CAP_WORDS),
    .CAP_BUILD (BUILD),
    .SOC_ID    (ID_VAL)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .cap_en  (cap_en)
  );

  // 100 MHz-style clock, rising edges at 5, 15, 25 ...
  always #5 sys_clk = ~sys_clk;

  function automatic logic [13:0] addr(input logic [4:0] idx);
    return {BANK, 5'd0, idx};
  endfunction

  // Drive one CSR cycle and return 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic [13:0] a, input logic we, input logic [31:0] d);
    csr_a  = a;
    csr_we = we;
    csr_di = d;
    @(posedge sys_clk);
    #1;
    csr_we = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    csr_a   = '0;
    csr_we  = 1'b0;
    csr_di  = '0;
    #1;
    checkOutput("rst_csr_do", 64'(csr_do), 64'd0);
    checkOutput("rst_cap_en", cap_en, BUILD);
    repeat (2) @(posedge sys_clk);
    #2 sys_rst = 1'b0;

    // Identification and build words
    applyStimulus(addr(5'h00), 1'b0, 32'd0);
    checkOutput("id", 64'(csr_do), 64'(ID_VAL));
    applyStimulus(addr(5'h08), 1'b0, 32'd0);
    checkOutput("build0", 64'(csr_do), 64'h41);
    applyStimulus(addr(5'h09), 1'b0, 32'd0);
    checkOutput("build1", 64'(csr_do), 64'h40);
    applyStimulus(addr(5'h01), 1'b0, 32'd0);
    checkOutput("ctrl_reset", 64'(csr_do), 64'h4);
    applyStimulus(addr(5'h10), 1'b0, 32'd0);
    checkOutput("mask0_reset", 64'(csr_do), 64'h41);

    // Mask write is filtered by the build word; read during write is old value
    applyStimulus(addr(5'h10), 1'b1, 32'hFFFF_FFFE);
    checkOutput("mask0_rdw", 64'(csr_do), 64'h41);
    applyStimulus(addr(5'h10), 1'b0, 32'd0);
    checkOutput("mask0_filtered", 64'(csr_do), 64'h40);
    checkOutput("cap_en_masked", cap_en, 64'h0000_0040_0000_0040);

    // Lock blocks further mask writes and cannot be cleared by software
    applyStimulus(addr(5'h01), 1'b1, 32'h1);
    applyStimulus(addr(5'h10), 1'b1, 32'h0);
    applyStimulus(addr(5'h10), 1'b0, 32'd0);
    checkOutput("mask0_locked", 64'(csr_do), 64'h40);
    applyStimulus(addr(5'h11), 1'b1, 32'h0);
    applyStimulus(addr(5'h11), 1'b0, 32'd0);
    checkOutput("mask1_locked", 64'(csr_do), 64'h40);
    applyStimulus(addr(5'h01), 1'b1, 32'h0);
    applyStimulus(addr(5'h01), 1'b0, 32'd0);
    checkOutput("lock_sticky", 64'(csr_do), 64'h1);

    // Counter is stopped (run=0); place it just below the 32-bit carry
    force dut.counter = 64'h0000_0000_FFFF_FFFF;
    applyStimulus(addr(5'h02), 1'b0, 32'd0);
    checkOutput("cnt_lo_pre", 64'(csr_do), 64'hFFFF_FFFF);
    release dut.counter;
    applyStimulus(addr(5'h01), 1'b1, 32'h4);
    applyStimulus(addr(5'h03), 1'b0, 32'd0);
    checkOutput("cnt_hi_snapshot", 64'(csr_do), 64'h0);
    applyStimulus(addr(5'h02), 1'b0, 32'd0);
    checkOutput("cnt_lo_wrapped", 64'(csr_do), 64'h0);
    applyStimulus(addr(5'h03), 1'b0, 32'd0);
    checkOutput("cnt_hi_carry", 64'(csr_do), 64'h1);

    // Clear while counting, then stop and verify the value holds
    applyStimulus(addr(5'h01), 1'b1, 32'h6);
    checkOutput("ctrl_rdw", 64'(csr_do), 64'h5);
    applyStimulus(addr(5'h02), 1'b0, 32'd0);
    checkOutput("cnt_after_clear_small", 64'(csr_do < 32'd2), 64'd1);
    applyStimulus(addr(5'h01), 1'b1, 32'h0);
    applyStimulus(addr(5'h02), 1'b0, 32'd0);
    checkOutput("cnt_stopped_a", 64'(csr_do), 64'h2);
    repeat (10) @(posedge sys_clk);
    #1;
    applyStimulus(addr(5'h02), 1'b0, 32'd0);
    checkOutput("cnt_stopped_b", 64'(csr_do), 64'h2);

    // Bank decode, ignored address bits and unmapped holes
    applyStimulus({4'h2, 5'd0, 5'h00}, 1'b0, 32'd0);
    checkOutput("other_bank_read", 64'(csr_do), 64'h0);
    applyStimulus({4'h2, 5'd0, 5'h04}, 1'b1, 32'h1234_5678);
    applyStimulus(addr(5'h04), 1'b0, 32'd0);
    checkOutput("other_bank_write", 64'(csr_do), 64'h0);
    applyStimulus({BANK, 5'h1F, 5'h00}, 1'b0, 32'd0);
    checkOutput("ignored_bits", 64'(csr_do), 64'(ID_VAL));
    applyStimulus(addr(5'h0A), 1'b0, 32'd0);
    checkOutput("hole_build", 64'(csr_do), 64'h0);
    applyStimulus(addr(5'h12), 1'b0, 32'd0);
    checkOutput("hole_mask", 64'(csr_do), 64'h0);

    // Scratch register
    applyStimulus(addr(5'h04), 1'b1, 32'hDEAD_BEEF);
    checkOutput("scratch_rdw", 64'(csr_do), 64'h0);
    applyStimulus(addr(5'h04), 1'b0, 32'd0);
    checkOutput("scratch", 64'(csr_do), 64'hDEAD_BEEF);

    // Asynchronous reset in the middle of a read
    applyStimulus(addr(5'h00), 1'b0, 32'd0);
    checkOutput("id_before_rst", 64'(csr_do), 64'(ID_VAL));
    #1 sys_rst = 1'b1;
    #1;
    checkOutput("async_csr_do", 64'(csr_do), 64'h0);
    checkOutput("async_cap_en", cap_en, BUILD);
    @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    applyStimulus(addr(5'h01), 1'b0, 32'd0);
    checkOutput("post_rst_ctrl", 64'(csr_do), 64'h4);
    applyStimulus(addr(5'h04), 1'b0, 32'd0);
    checkOutput("post_rst_scratch", 64'(csr_do), 64'h0);
    applyStimulus(addr(5'h03), 1'b0, 32'd0);
    checkOutput("post_rst_snap", 64'(csr_do), 64'h0);
    applyStimulus(addr(5'h10), 1'b0, 32'd0);
    checkOutput("post_rst_mask0", 64'(csr_do), 64'h41);
    applyStimulus(addr(5'h10), 1'b1, 32'h0);
    applyStimulus(addr(5'h10), 1'b0, 32'd0);
    checkOutput("post_rst_unlocked", 64'(csr_do), 64'h0);
    checkOutput("post_rst_cap_en", cap_en, 64'h0000_0040_0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
